// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: word width, default depth, response owner tag,
// and the address legality check used by the arbiter.
package imem_pkg;

    localparam int unsigned IMEM_WORD_W      = 32;
    localparam int unsigned IMEM_DEPTH_WORDS = 256;

    typedef enum logic {
        OWN_FETCH,
        OWN_LOADER
    } owner_e;

    // A byte address is illegal if it is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || (addr >= 32'(depth_words * 4));
    endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which fetch was blocked by the loader.
// force_fetch is raised once the count reaches STARVE_LIMIT (1..15).
// Only instantiated when IMEM_ARB_STARVE_EN is defined.
module imem_arb_starve_ctr
    import imem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic blocked,
    input  logic clear,
    output logic force_fetch
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;

    // Count blocked cycles, hold at the limit, clear on fetch grant or fetch idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else if (clear) begin
            starve_cnt_q <= 4'd0;
        end else if (blocked && (starve_cnt_q != LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end

    assign force_fetch = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares a single-port synchronous-read memory between the
// IF-stage fetch unit and the loader/debug port. Loader has priority; with
// IMEM_ARB_STARVE_EN defined, fetch is force-granted after STARVE_LIMIT blocked cycles.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = IMEM_DEPTH_WORDS,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // fetch port
    input  logic                           f_req_valid,
    input  logic [31:0]                    f_req_addr,
    output logic                           f_req_ready,
    output logic                           f_rsp_valid,
    output logic [IMEM_WORD_W-1:0]         f_rsp_data,
    output logic                           f_rsp_err,
    // loader port
    input  logic                           l_req_valid,
    input  logic                           l_req_we,
    input  logic [31:0]                    l_req_addr,
    input  logic [IMEM_WORD_W-1:0]         l_req_wdata,
    output logic                           l_req_ready,
    output logic                           l_rsp_valid,
    output logic [IMEM_WORD_W-1:0]         l_rsp_data,
    output logic                           l_rsp_err,
    // memory macro port
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [IMEM_WORD_W-1:0]         mem_wdata,
    input  logic [IMEM_WORD_W-1:0]         mem_rdata
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic   f_err, l_err;
    logic   f_go, l_go;
    logic   force_fetch;

    // Response pipeline: one entry, no back-pressure.
    logic   pending_q, pending_d;
    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   is_write_q, is_write_d;

    assign f_err = addr_bad(f_req_addr, DEPTH_WORDS);
    assign l_err = addr_bad(l_req_addr, DEPTH_WORDS);

`ifdef IMEM_ARB_STARVE_EN
    imem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .blocked     (f_req_valid && l_go),
        .clear       (f_go || !f_req_valid),
        .force_fetch (force_fetch)
    );
`else
    // Strict loader priority; the limit has no effect in this build.
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;
    assign force_fetch         = 1'b0;
`endif

    // Grant decision: at most one of f_go / l_go can be high.
    always_comb begin
        l_req_ready = !force_fetch;
        f_req_ready = force_fetch || !l_req_valid;
        l_go        = l_req_valid && l_req_ready;
        f_go        = f_req_valid && f_req_ready;
    end

    // Drive the memory port for the granted, legal request.
    always_comb begin
        mem_en    = (l_go && !l_err) || (f_go && !f_err);
        mem_we    = l_go && !l_err && l_req_we;
        mem_addr  = l_go ? l_req_addr[2 +: AW] : f_req_addr[2 +: AW];
        mem_wdata = l_req_wdata;
    end

    // Capture the accepted request's response attributes.
    always_comb begin
        pending_d  = f_go || l_go;
        owner_d    = l_go ? OWN_LOADER : OWN_FETCH;
        err_d      = l_go ? l_err : f_err;
        is_write_d = l_go && l_req_we;
    end

    // Response register; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            owner_q    <= OWN_FETCH;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            is_write_q <= is_write_d;
        end
    end

    // Route the registered memory output to the owner; data is zero on errors and writes.
    always_comb begin
        f_rsp_valid = pending_q && (owner_q == OWN_FETCH);
        l_rsp_valid = pending_q && (owner_q == OWN_LOADER);
        f_rsp_err   = f_rsp_valid && err_q;
        l_rsp_err   = l_rsp_valid && err_q;
        f_rsp_data  = (f_rsp_valid && !err_q) ? mem_rdata : '0;
        l_rsp_data  = (l_rsp_valid && !err_q && !is_write_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a write-first synchronous memory model.
// Contention expectations follow IMEM_ARB_STARVE_EN.
module tb_imem_arbiter;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LIMIT = 4;
`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic        l_req_valid;
    logic        l_req_we;
    logic [31:0] l_req_addr;
    logic [31:0] l_req_wdata;
    logic        l_req_ready;
    logic        l_rsp_valid;
    logic [31:0] l_rsp_data;
    logic        l_rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    imem_arbiter #(
        .DEPTH_WORDS  (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .l_req_valid (l_req_valid),
        .l_req_we    (l_req_we),
        .l_req_addr  (l_req_addr),
        .l_req_wdata (l_req_wdata),
        .l_req_ready (l_req_ready),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_data  (l_rsp_data),
        .l_rsp_err   (l_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req_valid = 1'b0;
        f_req_addr  = 32'h0;
        l_req_valid = 1'b0;
        l_req_we    = 1'b0;
        l_req_addr  = 32'h0;
        l_req_wdata = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_f_rsp_valid"}, f_rsp_valid, 0);
        check({tag, "_f_rsp_err"},   f_rsp_err,   0);
        check({tag, "_f_rsp_data"},  f_rsp_data,  0);
        check({tag, "_l_rsp_valid"}, l_rsp_valid, 0);
        check({tag, "_l_rsp_err"},   l_rsp_err,   0);
        check({tag, "_l_rsp_data"},  l_rsp_data,  0);
        check({tag, "_mem_en"},      mem_en,      0);
        check({tag, "_mem_we"},      mem_we,      0);
    endtask

    initial begin
        logic prev_f, prev_l, exp_f;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
        mem[0]    = 32'h0000_0013;
        mem[1]    = 32'h0050_0093;
        mem[2]    = 32'h00A0_0113;
        mem_rdata = 32'h0;

        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Fetch-only stream, first request in the first cycle out of reset.
        rst_n       = 1'b1;
        f_req_valid = 1'b1;
        f_req_addr  = 32'h0;
        #1;
        check("f0_ready",   f_req_ready, 1);
        check("f0_l_ready", l_req_ready, 1);
        check("f0_mem_en",  mem_en,      1);
        check("f0_mem_we",  mem_we,      0);
        check("f0_mem_addr", mem_addr,   0);
        step();
        f_req_addr = 32'h4;
        #1;
        check("f1_mem_addr", mem_addr,   1);
        check("f0_rsp_valid", f_rsp_valid, 1);
        check("f0_rsp_data",  f_rsp_data,  32'h0000_0013);
        check("f0_rsp_err",   f_rsp_err,   0);
        check("f0_l_rsp",     l_rsp_valid, 0);
        step();
        f_req_addr = 32'h8;
        #1;
        check("f1_rsp_valid", f_rsp_valid, 1);
        check("f1_rsp_data",  f_rsp_data,  32'h0050_0093);
        step();
        idle();
        #1;
        check("f2_rsp_valid", f_rsp_valid, 1);
        check("f2_rsp_data",  f_rsp_data,  32'h00A0_0113);
        check("f2_rsp_err",   f_rsp_err,   0);
        check("f2_idle_mem_en", mem_en,    0);
        step();
        #1;
        check("f_drain_valid", f_rsp_valid, 0);

        // Loader write, then fetch of the same word on the next cycle.
        l_req_valid = 1'b1;
        l_req_we    = 1'b1;
        l_req_addr  = 32'h10;
        l_req_wdata = 32'hDEAD_BEEF;
        #1;
        check("wr_l_ready",   l_req_ready, 1);
        check("wr_mem_en",    mem_en,      1);
        check("wr_mem_we",    mem_we,      1);
        check("wr_mem_addr",  mem_addr,    4);
        check("wr_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
        step();
        idle();
        f_req_valid = 1'b1;
        f_req_addr  = 32'h10;
        #1;
        check("wr_l_rsp_valid", l_rsp_valid, 1);
        check("wr_l_rsp_data",  l_rsp_data,  0);
        check("wr_l_rsp_err",   l_rsp_err,   0);
        check("wr_f_rsp_valid", f_rsp_valid, 0);
        check("raw_mem_we",     mem_we,      0);
        step();
        idle();
        #1;
        check("raw_f_rsp_valid", f_rsp_valid, 1);
        check("raw_f_rsp_data",  f_rsp_data,  32'hDEAD_BEEF);
        check("raw_l_rsp_valid", l_rsp_valid, 0);
        step();

        // Error cases: misaligned fetch, last legal word, out-of-range loader read.
        f_req_valid = 1'b1;
        f_req_addr  = 32'h2;
        #1;
        check("ferr_ready",  f_req_ready, 1);
        check("ferr_mem_en", mem_en,      0);
        step();
        idle();
        l_req_valid = 1'b1;
        l_req_we    = 1'b1;
        l_req_addr  = 32'h3FC;
        l_req_wdata = 32'h1234_5678;
        #1;
        check("ferr_rsp_valid", f_rsp_valid, 1);
        check("ferr_rsp_err",   f_rsp_err,   1);
        check("ferr_rsp_data",  f_rsp_data,  0);
        check("last_mem_en",    mem_en,      1);
        check("last_mem_addr",  mem_addr,    8'hFF);
        step();
        idle();
        l_req_valid = 1'b1;
        l_req_addr  = 32'h400;
        #1;
        check("lerr_ready",   l_req_ready, 1);
        check("lerr_mem_en",  mem_en,      0);
        check("last_rsp_err", l_rsp_err,   0);
        step();
        idle();
        #1;
        check("lerr_rsp_valid", l_rsp_valid, 1);
        check("lerr_rsp_err",   l_rsp_err,   1);
        check("lerr_rsp_data",  l_rsp_data,  0);
        check("lerr_f_rsp",     f_rsp_valid, 0);
        step();

        // Continuous contention: fetch 0x0 vs loader read 0x4.
        prev_f = 1'b0;
        prev_l = 1'b0;
        for (int k = 0; k < 10; k++) begin
            f_req_valid = 1'b1;
            f_req_addr  = 32'h0;
            l_req_valid = 1'b1;
            l_req_we    = 1'b0;
            l_req_addr  = 32'h4;
            #1;
            exp_f = STARVE_EN && ((k % 5) == 4);
            check("cont_f_ready",  f_req_ready, exp_f);
            check("cont_l_ready",  l_req_ready, !exp_f);
            check("cont_mem_en",   mem_en,      1);
            check("cont_mem_addr", mem_addr,    exp_f ? 0 : 1);
            check("cont_f_rsp",    f_rsp_valid, prev_f);
            check("cont_l_rsp",    l_rsp_valid, prev_l);
            if (prev_l) check("cont_l_data", l_rsp_data, 32'h0050_0093);
            if (prev_f) check("cont_f_data", f_rsp_data, 32'h0000_0013);
            prev_f = exp_f;
            prev_l = !exp_f;
            step();
        end
        idle();
        #1;
        check("cont_last_f_rsp", f_rsp_valid, prev_f);
        check("cont_last_l_rsp", l_rsp_valid, prev_l);
        step();

        // Alternating owners: loader read 0x10 / fetch 0x8.
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                if ((k % 2) == 0) begin
                    l_req_valid = 1'b1;
                    l_req_addr  = 32'h10;
                end else begin
                    f_req_valid = 1'b1;
                    f_req_addr  = 32'h8;
                end
            end
            #1;
            if (k > 0) begin
                prev_l = ((k - 1) % 2) == 0;
                check("alt_l_rsp",  l_rsp_valid, prev_l);
                check("alt_f_rsp",  f_rsp_valid, !prev_l);
                check("alt_l_data", l_rsp_data,  prev_l ? 32'hDEAD_BEEF : 32'h0);
                check("alt_f_data", f_rsp_data,  prev_l ? 32'h0 : 32'h00A0_0113);
                check("alt_both",   f_rsp_valid && l_rsp_valid, 0);
            end
            step();
        end

        // Reset while a loader read response is in flight.
        l_req_valid = 1'b1;
        l_req_addr  = 32'h0;
        #1;
        check("rst_acc_ready", l_req_ready, 1);
        check("rst_acc_en",    mem_en,      1);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rst_post_l_rsp", l_rsp_valid, 0);
            check("rst_post_f_rsp", f_rsp_valid, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port, synchronous-read instruction memory between two requesters: the IF-stage fetch unit and the program loader/debug port, which reads and writes words. Sits between the IF stage, the loader, and the memory macro. Once per cycle it grants at most one request, drives the memory port, and routes the one-cycle-late read data back to the owner. Loader has priority, with an optional anti-starvation guarantee for fetch.

## Interface
- DEPTH_WORDS, 256 — memory depth in 32-bit words; byte range is 0 .. DEPTH_WORDS*4-1
- STARVE_LIMIT, 4 — consecutive fetch-blocked cycles before fetch is force-granted (1..15)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request
- f_req_addr  in  32  fetch byte address
- f_req_ready  out  1  fetch request accepted this cycle
- f_rsp_valid  out  1  fetch response pulse
- f_rsp_data  out  32  fetched instruction; 0 when f_rsp_err
- f_rsp_err  out  1  misaligned or out-of-range fetch
- l_req_valid  in  1  loader request
- l_req_we  in  1  1 = write, 0 = read
- l_req_addr  in  32  loader byte address
- l_req_wdata  in  32  write data
- l_req_ready  out  1  loader request accepted this cycle
- l_rsp_valid  out  1  loader response pulse; issued for reads and writes
- l_rsp_data  out  32  read data; 0 for writes and errors
- l_rsp_err  out  1  misaligned or out-of-range loader access
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  $clog2(DEPTH_WORDS)  word index, equal to addr[2+:$clog2(DEPTH_WORDS)]
- mem_wdata  out  32  write data
- mem_rdata  in  32  registered memory output, valid the cycle after a read strobe

## Operation
- A request is accepted on a cycle with valid && ready. Both ready outputs are combinational.
- Default priority is loader: l_req_ready = 1; f_req_ready = !l_req_valid.
- A fetch is blocked on each cycle with f_req_valid && l_req_valid && loader granted. Each such cycle increments starve_cnt.
- starve_cnt clears on any cycle where fetch is accepted or f_req_valid = 0.
- When starve_cnt == STARVE_LIMIT, fetch wins: f_req_ready = 1, l_req_ready = 0. The counter clears after the grant.
- A request errors if addr[1:0] != 0 or addr >= DEPTH_WORDS*4.
  - An errored request is still accepted, but mem_en stays 0.
  - The next cycle gives a response with err = 1 and data = 0.
- For a good accepted request, the same cycle drives mem_en = 1, mem_we = l_req_we (0 for fetch), mem_addr and mem_wdata.
- With no grant, mem_en = mem_we = 0; mem_addr and mem_wdata are don't-care.
- The response pipeline register holds: pending, owner (FETCH/LOADER), err, is_write.
- Responses have no back-pressure. A requester must sink a one-cycle pulse.
- Writes never produce fetch-visible side effects in the same cycle. A fetch of the same word one cycle after a write returns the new data, per the memory macro's write-first behaviour.

## Timing
- Reset values: all rsp_valid = 0, rsp_err = 0, rsp_data = 0, starve_cnt = 0, pending = 0, mem_en = 0, mem_we = 0.
- Latency: accepted in cycle N gives rsp_valid in cycle N+1. rsp_data is mem_rdata passed through, gated by owner and !err.
- Throughput: one access per cycle, back-to-back. Owner can alternate every cycle.
- Simultaneous requests: exactly one is granted. The loser's ready = 0, and its valid and payload must be held stable until accepted.
- rst_n assertion mid-access drops any pending response; no rsp_valid appears after reset release for pre-reset requests. A write strobed on the cycle reset asserts is not guaranteed.
- Reset release: the first grant is possible in the first cycle with rst_n = 1.

## Configuration
- IMEM_ARB_STARVE_EN defined: the starve_cnt and forced-fetch-grant logic above are compiled in.
- IMEM_ARB_STARVE_EN undefined: strict loader priority. f_req_ready = !l_req_valid always, no counter, and STARVE_LIMIT is ignored.

## Structure
- Shared package imem_pkg holds:
  - typedef enum owner_e {OWN_FETCH, OWN_LOADER}
  - IMEM_WORD_W = 32
  - the default DEPTH_WORDS constant, also used by the memory and IF stage
- One sub-module, imem_arb_starve_ctr: saturating counter with inputs blocked/clear and output force_fetch. It is instantiated only under IMEM_ARB_STARVE_EN.

## Test plan
- Fetch only: addr 0x0, 0x4, 0x8 on consecutive cycles, with memory preloaded with 0x00000013, 0x00500093, 0x00A00113. Required: f_rsp_valid on the three following cycles with those words in order, err = 0.
- Loader write then fetch: loader writes 0xDEADBEEF to 0x10; fetch 0x10 next cycle. Required: l_rsp_valid with data 0 one cycle after the write; f_rsp_data = 0xDEADBEEF.
- Contention, STARVE_LIMIT = 4, both valid continuously:
  - macro on: loader granted 4 cycles, then fetch 1, repeating.
  - macro off: fetch never granted.
- Errors: fetch 0x2 and loader read 0x400 (DEPTH 256). Required: mem_en stays 0; next-cycle responses with err = 1, data = 0.
- Reset mid-access: a loader read is accepted, then rst_n is pulled low before the response. Required: all outputs at reset values; no l_rsp_valid after release.
- Back-to-back alternating loader read / fetch: owner routing is correct each cycle, and the two responses never assert in the same cycle.
